noc_local_injector: RTL and testbench

- Network-interface transmit stage that sits directly upstream of a mesh router's local input port. It drives that router's local_data_i and obeys its local_full_o.
- Accepts packet descriptors from a processing core through a valid/ready handshake and queues them in a small FIFO.
- Segments each descriptor plus a streamed payload into 17-bit head/body/tail flits and injects one flit per cycle whenever the router is not full.
- One instance per router; ROUTER_ID matches the attached router.

---
 rtl/noc_local_injector.sv | 144 ++++++++++++++
 tb/tb_noc_local_injector.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_injector.sv
// noc_local_injector: transmit stage in front of a mesh router's local port.
// Queues packet descriptors from the core, then emits head/body/tail flits,
// one per cycle, whenever the router reports room in its local buffer.
module noc_local_injector #(
   parameter logic [3:0] ROUTER_ID  = 4'd0,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [3:0]  req_dest_i,
   input  logic [3:0]  req_len_i,
   input  logic        pay_valid_i,
   output logic        pay_ready_o,
   input  logic [13:0] pay_data_i,
   input  logic        local_full_i,
   output logic [16:0] local_data_o,
   output logic        busy_o,
   output logic [15:0] pkt_sent_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

   state_t             state, state_next;
   logic [3:0]         fifo_dest [FIFO_DEPTH];
   logic [3:0]         fifo_len  [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [3:0]         desc_dest, desc_len;
   logic [3:0]         body_cnt, body_cnt_next;
   logic               full, empty, push, pop;
   logic               pending, xfer, tail_xfer;
   logic [16:0]        flit;

   // Head flit: valid, head, tail-if-empty-packet, then routing fields.
   function automatic logic [16:0] head_flit(input logic [3:0] dest, input logic [3:0] len);
      return {1'b1, 1'b1, (len == 4'd0), dest, ROUTER_ID, len, 2'b00};
   endfunction

   // Body flit: valid, no head, tail on the last word, then payload.
   function automatic logic [16:0] body_flit(input logic last, input logic [13:0] pay);
      return {1'b1, 1'b0, last, pay};
   endfunction

   assign full        = (count == CNT_W'(FIFO_DEPTH));
   assign empty       = (count == '0);
   // Ready is held low while reset is asserted, even though the FIFO is empty.
   assign req_ready_o = rst && !full;
   assign push        = req_valid_i && req_ready_o;
   assign busy_o      = !empty || (state != IDLE);

   // Next-state, flit selection and handshake outputs.
   always_comb begin
      state_next    = state;
      body_cnt_next = body_cnt;
      pending       = 1'b0;
      flit          = '0;
      tail_xfer     = 1'b0;
      pop           = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = HEAD;
            end
         end
         HEAD: begin
            pending = 1'b1;
            flit    = head_flit(desc_dest, desc_len);
            if (!local_full_i) begin
               if (desc_len == 4'd0) begin
                  tail_xfer = 1'b1;
               end else begin
                  body_cnt_next = desc_len;
                  state_next    = BODY;
               end
            end
         end
         BODY: begin
            pending = pay_valid_i;
            flit    = body_flit(body_cnt == 4'd1, pay_data_i);
            if (pay_valid_i && !local_full_i) begin
               body_cnt_next = body_cnt - 4'd1;
               if (body_cnt == 4'd1) begin
                  tail_xfer = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      // After a tail, chain straight into the next queued packet with no bubble.
      if (tail_xfer) begin
         if (!empty) begin
            pop        = 1'b1;
            state_next = HEAD;
         end else begin
            state_next = IDLE;
         end
      end
      xfer         = pending && !local_full_i;
      local_data_o = xfer ? flit : '0;
      pay_ready_o  = (state == BODY) && pay_valid_i && !local_full_i;
   end

   // Control state: FSM, FIFO pointers/occupancy, body counter, packet counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         body_cnt   <= '0;
         pkt_sent_o <= '0;
      end else begin
         state    <= state_next;
         body_cnt <= body_cnt_next;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (tail_xfer) pkt_sent_o <= pkt_sent_o + 16'd1;
      end
   end

   // Descriptor storage and the active descriptor; contents only matter once valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_dest[wr_ptr] <= req_dest_i;
         fifo_len[wr_ptr]  <= req_len_i;
      end
      if (pop) begin
         desc_dest <= fifo_dest[rd_ptr];
         desc_len  <= fifo_len[rd_ptr];
      end
   end

endmodule

// File: tb/tb_noc_local_injector.sv
// Randomised bench for noc_local_injector with a packet-level reference model
// plus directed scenarios pinned by hand-computed flit values.
module tb_noc_local_injector;

   localparam logic [3:0] RID   = 4'd0;
   localparam int         DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [3:0]  req_dest_i;
   logic [3:0]  req_len_i;
   logic        pay_valid_i;
   logic        pay_ready_o;
   logic [13:0] pay_data_i;
   logic        local_full_i;
   logic [16:0] local_data_o;
   logic        busy_o;
   logic [15:0] pkt_sent_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: queued descriptors, the packet in flight and the flit index within it.
   logic [3:0]  q_dest[$];
   logic [3:0]  q_len[$];
   bit          active;
   logic [3:0]  cur_dest, cur_len;
   int          pos;
   logic [15:0] m_sent;

   logic [16:0] obs_data;
   logic        obs_ready, obs_pay_ready, obs_busy;
   logic [15:0] obs_sent;

   noc_local_injector #(.ROUTER_ID(RID), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_dest_i   (req_dest_i),
      .req_len_i    (req_len_i),
      .pay_valid_i  (pay_valid_i),
      .pay_ready_o  (pay_ready_o),
      .pay_data_i   (pay_data_i),
      .local_full_i (local_full_i),
      .local_data_o (local_data_o),
      .busy_o       (busy_o),
      .pkt_sent_o   (pkt_sent_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Flit index 0 is the head; indices 1..len are body words, the last one is the tail.
   task automatic model_out(output bit pend, output logic [16:0] f);
      pend = 1'b0;
      f    = '0;
      if (active) begin
         if (pos == 0) begin
            pend = 1'b1;
            f    = {1'b1, 1'b1, (cur_len == 4'd0), cur_dest, RID, cur_len, 2'b00};
         end else begin
            pend = pay_valid_i;
            f    = {1'b1, 1'b0, (pos == int'(cur_len)), pay_data_i};
         end
      end
   endtask

   task automatic model_clear();
      q_dest.delete();
      q_len.delete();
      active = 1'b0;
      pos    = 0;
      m_sent = '0;
   endtask

   // One clock cycle: drive, compare all outputs against the model, then advance the model.
   task automatic step(input bit rv, input logic [3:0] d, input logic [3:0] l,
                       input bit pv, input logic [13:0] pd, input bit fl);
      bit          pend, xfer, done, push, pop;
      logic [16:0] f;
      @(negedge clk);
      req_valid_i  = rv;
      req_dest_i   = d;
      req_len_i    = l;
      pay_valid_i  = pv;
      pay_data_i   = pd;
      local_full_i = fl;
      #1;
      model_out(pend, f);
      xfer = pend && !fl;
      check("local_data", local_data_o, xfer ? f : 17'b0);
      check("req_ready", req_ready_o, q_dest.size() < DEPTH);
      check("pay_ready", pay_ready_o, active && (pos > 0) && pv && !fl);
      check("busy", busy_o, (q_dest.size() != 0) || active);
      check("pkt_sent", pkt_sent_o, m_sent);
      obs_data      = local_data_o;
      obs_ready     = req_ready_o;
      obs_pay_ready = pay_ready_o;
      obs_busy      = busy_o;
      obs_sent      = pkt_sent_o;
      @(posedge clk);
      done = xfer && f[14];
      push = rv && (q_dest.size() < DEPTH);
      pop  = (q_dest.size() > 0) && (!active || done);
      if (xfer) pos++;
      if (done) begin
         m_sent++;
         active = 1'b0;
      end
      if (pop) begin
         cur_dest = q_dest.pop_front();
         cur_len  = q_len.pop_front();
         active   = 1'b1;
         pos      = 0;
      end
      if (push) begin
         q_dest.push_back(d);
         q_len.push_back(l);
      end
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear at once.
   task automatic reset_mid();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_local_data", local_data_o, 17'b0);
      check("rst_pay_ready", pay_ready_o, 1'b0);
      check("rst_req_ready", req_ready_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_pkt_sent", pkt_sent_o, 16'd0);
      model_clear();
      req_valid_i = 1'b0;
      pay_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      bit          rv, pv, fl, hold, exp_pr;
      logic [3:0]  rd, rl;
      logic [13:0] rpd;

      rst          = 1'b0;
      req_valid_i  = 1'b0;
      req_dest_i   = '0;
      req_len_i    = '0;
      pay_valid_i  = 1'b0;
      pay_data_i   = '0;
      local_full_i = 1'b0;
      model_clear();
      #1;
      check("reset_local_data", local_data_o, 17'b0);
      check("reset_req_ready", req_ready_o, 1'b0);
      check("reset_pay_ready", pay_ready_o, 1'b0);
      check("reset_busy", busy_o, 1'b0);
      check("reset_pkt_sent", pkt_sent_o, 16'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Single packet dest=5 len=2
      step(1, 4'd5, 4'd2, 0, 14'h0, 0);
      check("idle_before_push", obs_data, 17'h0);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("no_head_yet", obs_data, 17'h0);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("head_5_2", obs_data, 17'h1_9408);
      step(0, 4'd0, 4'd0, 1, 14'h1234, 0);
      check("body_1234", obs_data, 17'h1_1234);
      step(0, 4'd0, 4'd0, 1, 14'h0ABC, 0);
      check("tail_0ABC", obs_data, 17'h1_4ABC);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("sent_after_first", obs_sent, 16'd1);
      check("idle_after_first", obs_busy, 1'b0);

      // Zero-length packet dest=15
      step(1, 4'd15, 4'd0, 0, 14'h0, 0);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("head_tail_zero_len", obs_data, 17'h1_FC00);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("sent_after_zero_len", obs_sent, 16'd2);

      // Backpressure then payload starvation, dest=2 len=3
      step(1, 4'd2, 4'd3, 0, 14'h0, 0);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("head_2_3", obs_data, 17'h1_880C);
      for (int i = 0; i < 3; i++) begin
         step(0, 4'd0, 4'd0, 1, 14'h0111, 1);
         check("stall_data", obs_data, 17'h0);
         check("stall_pay_ready", obs_pay_ready, 1'b0);
      end
      step(0, 4'd0, 4'd0, 1, 14'h0111, 0);
      check("body_after_stall", obs_data, 17'h1_0111);
      for (int i = 0; i < 4; i++) begin
         step(0, 4'd0, 4'd0, 0, 14'h0222, 0);
         check("starve_data", obs_data, 17'h0);
      end
      step(0, 4'd0, 4'd0, 1, 14'h0222, 0);
      check("body_after_starve", obs_data, 17'h1_0222);
      step(0, 4'd0, 4'd0, 1, 14'h0333, 0);
      check("tail_0333", obs_data, 17'h1_4333);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("sent_after_bp", obs_sent, 16'd3);

      // Fill the FIFO while the router is full, then drain back-to-back
      for (int i = 0; i < 6; i++) begin
         step(1, 4'(i), 4'd1, 1, 14'($urandom), 1);
      end
      check("ready_low_when_full", obs_ready, 1'b0);
      for (int i = 0; i < 12; i++) begin
         step(0, 4'd0, 4'd0, 1, 14'($urandom), 0);
      end
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("sent_after_burst", obs_sent, 16'd8);
      check("idle_after_burst", obs_busy, 1'b0);

      // Reset in the middle of a body
      step(1, 4'd3, 4'd5, 0, 14'h0, 0);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      step(0, 4'd0, 4'd0, 1, 14'h0055, 0);
      reset_mid();
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("sent_restart", obs_sent, 16'd0);
      step(1, 4'd9, 4'd0, 0, 14'h0, 0);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("head_after_reset", obs_data, 17'h1_E400);
      step(0, 4'd0, 4'd0, 0, 14'h0, 0);
      check("sent_after_reset", obs_sent, 16'd1);

      // Randomised traffic against the model
      hold = 1'b0;
      rv   = 1'b0;
      rd   = '0;
      rl   = '0;
      rpd  = 14'($urandom);
      for (int c = 0; c < 4000; c++) begin
         if (!hold) begin
            rv = ($urandom_range(0, 99) < 40);
            rd = 4'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
         end
         pv     = ($urandom_range(0, 99) < 75);
         fl     = ($urandom_range(0, 99) < 25);
         hold   = rv && !(q_dest.size() < DEPTH);
         exp_pr = active && (pos > 0) && pv && !fl;
         step(rv, rd, rl, pv, rpd, fl);
         if (exp_pr) rpd = 14'($urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
